// File: rtl/io_bus_pkg.sv
// Shared encodings for the CPU-to-io_ports bus sequencer.
package io_bus_pkg;

  localparam int unsigned IO_ADDR_W = 4;
  localparam int unsigned OP_W      = 2;

  typedef enum logic [OP_W-1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_TOGGLE = 2'b10,
    OP_RSVD   = 2'b11
  } io_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_TW,
    ST_RESP,
    ST_SETTLE
  } io_state_e;

  // Request header as latched at acceptance.
  typedef struct packed {
    io_op_e                 op;
    logic [IO_ADDR_W-1:0]   addr;
  } io_req_hdr_t;

  // A request is rejected without a bus cycle for a reserved op or an unmapped port.
  function automatic logic is_bad_req(input io_req_hdr_t hdr, input int unsigned num_ports);
    return (hdr.op == OP_RSVD) || (32'(hdr.addr) >= num_ports);
  endfunction

endpackage

// File: rtl/io_settle_timer.sv
// Post-write settle counter: loads SETTLE_CYCLES-1 and counts down to zero.
module io_settle_timer
  import io_bus_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done_c
);

  localparam int unsigned CNT_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned LOAD_VAL = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CNT_W'(LOAD_VAL);
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/io_bus_ctrl.sv
// Sequences one CPU I/O request at a time into a timed io_ports bus cycle and
// returns the result over a valid/ready response channel.
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int unsigned BITS          = 16,
  parameter int unsigned NUM_PORTS     = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OP_W-1:0]      req_op,
  input  logic [IO_ADDR_W-1:0] req_addr,
  input  logic [BITS-1:0]      req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic                 io_en,
  output logic                 io_r_or_w,
  output logic [IO_ADDR_W-1:0] io_addr,
  output logic [BITS-1:0]      io_wdata,
  input  logic [BITS-1:0]      io_rdata
);

  localparam bit HAS_SETTLE = (SETTLE_CYCLES > 0);

  io_state_e            state_q, state_d;
  io_req_hdr_t          hdr_q, hdr_d;
  io_req_hdr_t          req_hdr_c;
  logic                 wrote_q, wrote_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [BITS-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 io_en_q, io_en_d;
  logic                 io_r_or_w_q, io_r_or_w_d;
  logic [IO_ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [BITS-1:0]      io_wdata_q, io_wdata_d;
  logic                 settle_load_c;
  logic                 settle_done_c;

  assign req_hdr_c = '{op: io_op_e'(req_op), addr: req_addr};

  io_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (settle_load_c),
    .done_c (settle_done_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '{op: OP_READ, addr: '0};
      wrote_q     <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      io_en_q     <= 1'b0;
      io_r_or_w_q <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      wrote_q     <= wrote_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      io_en_q     <= io_en_d;
      io_r_or_w_q <= io_r_or_w_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    wrote_d       = wrote_q;
    req_ready_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    io_en_d       = 1'b0;
    io_r_or_w_d   = io_r_or_w_q;
    io_addr_d     = io_addr_q;
    io_wdata_d    = io_wdata_q;
    settle_load_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          hdr_d       = req_hdr_c;
          wrote_d     = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (is_bad_req(req_hdr_c, NUM_PORTS)) begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            io_en_d   = 1'b1;
            io_addr_d = req_addr;
            if (req_hdr_c.op == OP_WRITE) begin
              io_r_or_w_d = 1'b1;
              io_wdata_d  = req_wdata;
              wrote_d     = 1'b1;
              state_d     = ST_WR;
            end else begin
              io_r_or_w_d = 1'b0;
              state_d     = ST_RD;
            end
          end
        end
      end

      // io_rdata was registered by io_ports on the falling edge of this cycle.
      ST_RD: begin
        rsp_rdata_d = io_rdata;
        if (hdr_q.op == OP_TOGGLE) begin
          io_en_d     = 1'b1;
          io_r_or_w_d = 1'b1;
          io_addr_d   = hdr_q.addr;
          io_wdata_d  = {{(BITS-1){1'b0}}, ~io_rdata[0]};
          wrote_d     = 1'b1;
          state_d     = ST_TW;
        end else begin
          io_r_or_w_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_WR, ST_TW: begin
        io_r_or_w_d = 1'b0;
        io_wdata_d  = '0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (wrote_q && HAS_SETTLE) begin
            settle_load_c = 1'b1;
            state_d       = ST_SETTLE;
          end else begin
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_SETTLE: begin
        if (settle_done_c) begin
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign io_en     = io_en_q;
  assign io_r_or_w = io_r_or_w_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;

endmodule
